// File: rtl/ped_req_cond_pkg.sv
// Shared definitions for the pedestrian request conditioner: FSM encodings,
// default timing constants and the system clock rate it shares with main_ltc.
package ped_req_cond_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        FIRE     = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam int CLK_HZ       = 1000;   // 1 kHz system tick
    localparam int DB_CYC_DEF   = 20;     // 20 ms debounce
    localparam int LOCK_CYC_DEF = 50000;  // 50 s lockout

endpackage

// File: rtl/ped_req_cond_btn_sync2.sv
// Two-flop synchroniser for the raw push-button plus a delayed copy used to
// detect the rising edge of the synchronised level.
module btn_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_s,
    output logic rise
);

    logic s1;
    logic btn_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            btn_s   <= 1'b0;
            btn_s_d <= 1'b0;
        end else begin
            s1      <= btn_raw;
            btn_s   <= s1;
            btn_s_d <= btn_s;
        end
    end

    assign rise = btn_s & ~btn_s_d;

endmodule

// File: rtl/ped_req_cond.sv
// Debounces the pedestrian button and issues one N pulse per accepted press,
// with a lockout window that can hold at most one queued press.
module ped_req_cond
    import ped_req_cond_pkg::*;
#(
    parameter int DB_CYC   = DB_CYC_DEF,
    parameter int LOCK_CYC = LOCK_CYC_DEF,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    output logic             N,
    output logic             busy,
    output logic             pending,
    output logic [CNT_W-1:0] fire_cnt
);

    localparam int DB_W = $clog2(DB_CYC + 1);
    localparam int LK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    logic btn_s;
    logic rise;

    btn_sync2 u_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn_s   (btn_s),
        .rise    (rise)
    );

    state_t          state, state_nx;
    logic [DB_W-1:0] db_cnt, db_nx;
    logic [LK_W-1:0] lk_cnt, lk_nx;
    logic            pend_nx;

    always_comb begin
        state_nx = state;
        db_nx    = db_cnt;
        lk_nx    = lk_cnt;
        pend_nx  = pending;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nx = DEBOUNCE;
                    db_nx    = DB_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                    db_nx    = '0;
                end else if (db_cnt == DB_W'(DB_CYC)) begin
                    state_nx = FIRE;
                    db_nx    = '0;
                end else begin
                    db_nx = db_cnt + DB_W'(1);
                end
            end
            FIRE: begin
                lk_nx    = '0;
                state_nx = LOCKOUT;
            end
            LOCKOUT: begin
                lk_nx = lk_cnt + LK_W'(1);
                // Only the first rise is queued; later ones are dropped.
                if (rise) pend_nx = 1'b1;
                if (lk_cnt == LK_W'(LOCK_CYC - 1)) begin
                    lk_nx    = '0;
                    state_nx = (pending || rise) ? FIRE : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Entering FIRE consumes any queued press.
        if (state_nx == FIRE) pend_nx = 1'b0;
    end

    // Outputs are registered from the next state so N lines up with FIRE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            db_cnt   <= '0;
            lk_cnt   <= '0;
            N        <= 1'b0;
            busy     <= 1'b0;
            pending  <= 1'b0;
            fire_cnt <= '0;
        end else begin
            state   <= state_nx;
            db_cnt  <= db_nx;
            lk_cnt  <= lk_nx;
            pending <= pend_nx;
            N       <= (state_nx == FIRE);
            busy    <= (state_nx == FIRE) || (state_nx == LOCKOUT);
            if (state_nx == FIRE && fire_cnt != '1)
                fire_cnt <= fire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ped_req_cond.sv
// Bench for ped_req_cond: expected N pulse cycles are queued as each press is
// driven and matched against the pulses the DUT actually produces.
module tb_ped_req_cond;

    localparam int DB   = 4;
    localparam int LK   = 16;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_raw = 1'b0;
    logic          N;
    logic          busy;
    logic          pending;
    logic [CW-1:0] fire_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_q[$];

    ped_req_cond #(.DB_CYC(DB), .LOCK_CYC(LK), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .N        (N),
        .busy     (busy),
        .pending  (pending),
        .fire_cnt (fire_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Walk to the falling edge at which cyc == t.
    task automatic goto(input int t);
        if (cyc > t) chk("sched", cyc, t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        chk("q_empty", exp_q.size(), 0);
        exp_q.delete();
        btn_raw = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic async_rst_pulse(input string tag);
        #1 rst = 1'b1;
        #1;
        chk({tag, "_N"},       int'(N), 0);
        chk({tag, "_busy"},    int'(busy), 0);
        chk({tag, "_pending"}, int'(pending), 0);
        chk({tag, "_cnt"},     int'(fire_cnt), 0);
        rst = 1'b0;
    endtask

    // Pulse monitor: every N must match the head of the queue.
    always @(negedge clk) begin
        int e;
        if (N) begin
            if (exp_q.size() == 0) chk("n_unexp", int'(N), 0);
            else begin
                e = exp_q.pop_front();
                chk("n_time", cyc, e);
            end
        end else if (exp_q.size() > 0 && cyc >= exp_q[0]) begin
            e = exp_q.pop_front();
            chk("n_miss", int'(N), 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        @(negedge clk);
        chk("rst_N",       int'(N), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_cnt",     int'(fire_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean press held 40 cycles: one pulse, then auto-repeat after lockout.
        t = cyc;
        btn_raw = 1'b1;
        exp_q.push_back(t + 7);
        exp_q.push_back(t + 29);
        goto(t + 6);  chk("s1_busy_pre", int'(busy), 0); chk("s1_cnt0", int'(fire_cnt), 0);
        goto(t + 7);  chk("s1_busy_f", int'(busy), 1);   chk("s1_cnt1", int'(fire_cnt), 1);
                      chk("s1_pend", int'(pending), 0);
        goto(t + 23); chk("s1_busy_end", int'(busy), 1);
        goto(t + 24); chk("s1_busy_off", int'(busy), 0);
        goto(t + 40); btn_raw = 1'b0;
        goto(t + 50); chk("s1_busy_idle", int'(busy), 0); chk("s1_cnt2", int'(fire_cnt), 2);

        // Bounce then stable press.
        do_reset();
        t = cyc;
        btn_raw = 1'b1;
        goto(t + 2); btn_raw = 1'b0;
        goto(t + 4); btn_raw = 1'b1;
        goto(t + 6); btn_raw = 1'b0;
        goto(t + 8); btn_raw = 1'b1;
        exp_q.push_back(t + 15);
        goto(t + 14); chk("s2_busy_pre", int'(busy), 0); chk("s2_cnt0", int'(fire_cnt), 0);
        goto(t + 15); chk("s2_cnt1", int'(fire_cnt), 1);
        goto(t + 20); btn_raw = 1'b0;
        goto(t + 36); chk("s2_busy_idle", int'(busy), 0);

        // Several presses during lockout queue exactly one extra pulse.
        do_reset();
        t = cyc;
        btn_raw = 1'b1;
        exp_q.push_back(t + 7);
        goto(t + 10); btn_raw = 1'b0;
        goto(t + 12); btn_raw = 1'b1;
        goto(t + 14); chk("s3_pend0", int'(pending), 0); btn_raw = 1'b0;
        goto(t + 15); chk("s3_pend1", int'(pending), 1);
        goto(t + 16); btn_raw = 1'b1;
        goto(t + 18); btn_raw = 1'b0;
        goto(t + 20); btn_raw = 1'b1;
        exp_q.push_back(t + 24);
        goto(t + 22); btn_raw = 1'b0;
        goto(t + 23); chk("s3_pend_hold", int'(pending), 1); chk("s3_cnt1", int'(fire_cnt), 1);
        goto(t + 24); chk("s3_pend_clr", int'(pending), 0); chk("s3_cnt2", int'(fire_cnt), 2);
                      chk("s3_busy", int'(busy), 1);
        goto(t + 45); chk("s3_busy_idle", int'(busy), 0); chk("s3_pend_idle", int'(pending), 0);

        // Rise on the final lockout cycle fires right after lockout.
        do_reset();
        t = cyc;
        btn_raw = 1'b1;
        exp_q.push_back(t + 7);
        goto(t + 10); btn_raw = 1'b0;
        goto(t + 21); btn_raw = 1'b1;
        exp_q.push_back(t + 24);
        goto(t + 23); chk("s4_pend", int'(pending), 0); chk("s4_busy", int'(busy), 1);
        goto(t + 24); chk("s4_cnt2", int'(fire_cnt), 2); chk("s4_pend_f", int'(pending), 0);
        goto(t + 26); btn_raw = 1'b0;
        goto(t + 45); chk("s4_busy_idle", int'(busy), 0);

        // Asynchronous reset mid-DEBOUNCE (press discarded) and mid-LOCKOUT.
        do_reset();
        t = cyc;
        btn_raw = 1'b1;
        goto(t + 5); async_rst_pulse("s5_db");
        exp_q.push_back(t + 12);
        goto(t + 7);  chk("s5_discard", int'(fire_cnt), 0);
        goto(t + 12); chk("s5_cnt1", int'(fire_cnt), 1); chk("s5_busy", int'(busy), 1);
        goto(t + 14); btn_raw = 1'b0;
        goto(t + 17); btn_raw = 1'b1;
        goto(t + 19); btn_raw = 1'b0;
        goto(t + 21); chk("s5_pend", int'(pending), 1); chk("s5_busy_lk", int'(busy), 1);
        async_rst_pulse("s5_lk");
        goto(t + 45); chk("s5_busy_idle", int'(busy), 0); chk("s5_cnt_idle", int'(fire_cnt), 0);

        // Counter saturation at 2^CNT_W-1.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            t = cyc;
            btn_raw = 1'b1;
            exp_q.push_back(t + 7);
            goto(t + 7);  chk("s6_sat", int'(fire_cnt), (k > 3) ? 3 : k);
            goto(t + 10); btn_raw = 1'b0;
            goto(t + 26);
        end
        chk("s6_final", int'(fire_cnt), 3);
        chk("q_final", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
